// File: rtl/mips_pkg.sv
// Shared definitions for the Lite_MIPS run monitor.
//   state_t      : run-controller FSM states
//   HALT_*       : halt_cause encodings, {zero_hit, budget_hit}
//   DEF_W, DEF_L : default word width and address bits of the Lite_MIPS memories
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] HALT_NONE   = 2'b00;
  localparam logic [1:0] HALT_BUDGET = 2'b01;
  localparam logic [1:0] HALT_ZERO   = 2'b10;
  localparam logic [1:0] HALT_BOTH   = 2'b11;

  localparam int DEF_W = 32;
  localparam int DEF_L = 6;

endpackage

// File: rtl/mips_zero_run_detect.sv
// Combinational zero-run detector.
// Reports whether the ZERO_RUN instruction words starting at pc are all zero.
// The window wraps modulo N = 2**L, so a run may straddle word N-1 and word 0.
// Ports:
//   pc       in  L      current word PC
//   inst_mem in  W*N    flattened instruction memory, word g at [(g+1)*W-1:g*W]
//   zero_hit out 1      all words in the window are zero
module mips_zero_run_detect #(
  parameter int W        = 32,
  parameter int L        = 6,
  parameter int ZERO_RUN = 2
) (
  input  logic [L-1:0]          pc,
  input  logic [W*(2**L)-1:0]   inst_mem,
  output logic                  zero_hit
);

  logic [L-1:0] idx;

  always_comb begin
    zero_hit = 1'b1;
    idx      = '0;
    for (int k = 0; k < ZERO_RUN; k++) begin
      // L-bit addition truncates, which is exactly the modulo-N wrap
      idx = pc + L'(k);
      if (inst_mem[idx*W +: W] != '0) zero_hit = 1'b0;
    end
  end

endmodule

// File: rtl/mips_run_monitor.sv
// Synthesizable run controller for Lite_MIPS.
// Enables the core while running, counts executed cycles, halts on a cycle budget
// or on a run of zero instructions at the PC, then streams a data-memory window
// out over a valid/ready port.
// Ports:
//   clk               in   1    clock, rising edge
//   rst               in   1    asynchronous active-low reset
//   start             in   1    start/restart request, honoured in IDLE and DONE
//   pc_current        in   L    core word PC
//   inst_mem_in_wire  in   W*N  flattened instruction memory
//   data_mem_out_wire in   W*N  flattened data memory
//   core_en           out  1    core clock enable
//   halted            out  1    high in DUMP and DONE
//   halt_cause        out  2    {zero_hit, budget_hit} captured at halt
//   cycle_count       out  CW   executed cycles
//   dump_valid        out  1    dump word available
//   dump_ready        in   1    consumer accepts word
//   dump_addr         out  L    word index of dump_data
//   dump_data         out  W    data memory word at dump_addr
//   dump_last         out  1    final word of the dump window
//   done              out  1    dump complete
module mips_run_monitor
  import mips_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int L        = DEF_L,
  parameter int CC       = 60,
  parameter int ZERO_RUN = 2,
  parameter int DUMP_LO  = 0,
  parameter int DUMP_HI  = (2**L) - 1,
  localparam int N       = 2**L,
  localparam int CW      = ($clog2(CC + 1) < 1) ? 1 : $clog2(CC + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [L-1:0]   pc_current,
  input  logic [W*N-1:0] inst_mem_in_wire,
  input  logic [W*N-1:0] data_mem_out_wire,
  output logic           core_en,
  output logic           halted,
  output logic [1:0]     halt_cause,
  output logic [CW-1:0]  cycle_count,
  output logic           dump_valid,
  input  logic           dump_ready,
  output logic [L-1:0]   dump_addr,
  output logic [W-1:0]   dump_data,
  output logic           dump_last,
  output logic           done
);

  localparam logic [L-1:0]  ADDR_LO = L'(DUMP_LO);
  localparam logic [L-1:0]  ADDR_HI = L'(DUMP_HI);
  localparam logic [CW-1:0] BUDGET  = CW'(CC);

  state_t state_q, state_d;
  logic   zero_hit;
  logic   budget_hit;
  logic   halt_now;
  logic   handshake;
  logic   at_hi;

  mips_zero_run_detect #(
    .W        (W),
    .L        (L),
    .ZERO_RUN (ZERO_RUN)
  ) u_zero_run (
    .pc       (pc_current),
    .inst_mem (inst_mem_in_wire),
    .zero_hit (zero_hit)
  );

  assign budget_hit = (cycle_count == BUDGET);
  // Halt decision is combinational so the core is frozen on the very edge
  // that moves us into DUMP.
  assign halt_now   = (state_q == RUN) && (zero_hit || budget_hit);
  assign handshake  = dump_valid && dump_ready;
  assign at_hi      = (dump_addr == ADDR_HI);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)              state_d = RUN;
      RUN:     if (halt_now)           state_d = DUMP;
      DUMP:    if (handshake && at_hi) state_d = DONE;
      DONE:    if (start)              state_d = RUN;
      default:                         state_d = IDLE;
    endcase
  end

  // Cycle counter, halt cause and dump address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
      halt_cause  <= HALT_NONE;
      dump_addr   <= ADDR_LO;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            cycle_count <= '0;
            halt_cause  <= HALT_NONE;
            dump_addr   <= ADDR_LO;
          end
        end
        RUN: begin
          if (halt_now) halt_cause  <= {zero_hit, budget_hit};
          else          cycle_count <= cycle_count + CW'(1);
        end
        DUMP: begin
          // The final word leaves the address at DUMP_HI for DONE to hold.
          if (handshake && !at_hi) dump_addr <= dump_addr + L'(1);
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    core_en    = (state_q == RUN) && !halt_now;
    halted     = (state_q == DUMP) || (state_q == DONE);
    dump_valid = (state_q == DUMP);
    done       = (state_q == DONE);
    dump_last  = dump_valid && at_hi;
    dump_data  = '0;
    if (halted) dump_data = data_mem_out_wire[dump_addr*W +: W];
  end

endmodule

// File: tb/tb_mips_run_monitor.sv
module tb_mips_run_monitor;
  import mips_pkg::*;

  localparam int W  = 32;
  localparam int L  = 6;
  localparam int N  = 64;
  localparam int CC = 60;
  localparam int ZR = 2;
  localparam int LO = 0;
  localparam int HI = 7;

  typedef struct {
    int pc;
    int cnt;
    int cause;
    int en;
  } halt_exp_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
    logic        last;
  } dump_exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [L-1:0]   pc_current;
  logic [W*N-1:0] inst_mem;
  logic [W*N-1:0] data_mem;
  logic           core_en;
  logic           halted;
  logic [1:0]     halt_cause;
  logic [5:0]     cycle_count;
  logic           dump_valid;
  logic           dump_ready;
  logic [L-1:0]   dump_addr;
  logic [W-1:0]   dump_data;
  logic           dump_last;
  logic           done;

  logic           pc_load;
  logic [L-1:0]   pc_val;

  int checks   = 0;
  int failures = 0;

  halt_exp_t halt_q[$];
  dump_exp_t dump_q[$];

  mips_run_monitor #(
    .W (W), .L (L), .CC (CC), .ZERO_RUN (ZR), .DUMP_LO (LO), .DUMP_HI (HI)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .pc_current        (pc_current),
    .inst_mem_in_wire  (inst_mem),
    .data_mem_out_wire (data_mem),
    .core_en           (core_en),
    .halted            (halted),
    .halt_cause        (halt_cause),
    .cycle_count       (cycle_count),
    .dump_valid        (dump_valid),
    .dump_ready        (dump_ready),
    .dump_addr         (dump_addr),
    .dump_data         (dump_data),
    .dump_last         (dump_last),
    .done              (done)
  );

  always #5 clk = ~clk;

  // Minimal core model: PC advances only while enabled.
  always @(posedge clk) begin
    if (pc_load)      pc_current <= pc_val;
    else if (core_en) pc_current <= pc_current + 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_core_en"}, 64'(core_en), 64'(0));
    check({tag, "_halted"},  64'(halted), 64'(0));
    check({tag, "_cause"},   64'(halt_cause), 64'(HALT_NONE));
    check({tag, "_count"},   64'(cycle_count), 64'(0));
    check({tag, "_valid"},   64'(dump_valid), 64'(0));
    check({tag, "_addr"},    64'(dump_addr), 64'(LO));
    check({tag, "_data"},    64'(dump_data), 64'(0));
    check({tag, "_last"},    64'(dump_last), 64'(0));
    check({tag, "_done"},    64'(done), 64'(0));
  endtask

  task automatic load_pc(input int v);
    pc_load = 1'b1;
    pc_val  = L'(v);
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic set_inst(input int g, input logic [31:0] v);
    inst_mem[g*W +: W] = v;
  endtask

  task automatic run_to_halt(input string tag);
    halt_exp_t e;
    int        en_cnt;
    logic      last_en;
    logic      seen;
    e       = halt_q.pop_front();
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    en_cnt  = 0;
    last_en = 1'b1;
    seen    = 1'b0;
    check({tag, "_count_start"}, 64'(cycle_count), 64'(0));
    for (int i = 0; i < 300; i++) begin
      if (halted) begin
        seen = 1'b1;
        break;
      end
      last_en = core_en;
      if (core_en) en_cnt++;
      @(negedge clk);
    end
    check({tag, "_halt_seen"},   64'(seen), 64'(1));
    check({tag, "_pc"},          64'(pc_current), 64'(e.pc));
    check({tag, "_count"},       64'(cycle_count), 64'(e.cnt));
    check({tag, "_cause"},       64'(halt_cause), 64'(e.cause));
    check({tag, "_en_cycles"},   64'(en_cnt), 64'(e.en));
    check({tag, "_en_halt_cyc"}, 64'(last_en), 64'(0));
  endtask

  task automatic run_dump(input string tag, input logic toggle);
    dump_exp_t e;
    logic      ph;
    for (int a = LO; a <= HI; a++)
      dump_q.push_back('{a, data_mem[a*W +: W], (a == HI)});
    ph = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (dump_q.size() == 0) break;
      dump_ready = toggle ? ph : 1'b1;
      ph = !ph;
      #1;
      e = dump_q[0];
      check({tag, "_valid"}, 64'(dump_valid), 64'(1));
      check({tag, "_addr"},  64'(dump_addr), 64'(e.addr));
      check({tag, "_data"},  64'(dump_data), 64'(e.data));
      check({tag, "_last"},  64'(dump_last), 64'(e.last));
      if (dump_ready) void'(dump_q.pop_front());
      @(negedge clk);
    end
    check({tag, "_drained"}, 64'(dump_q.size()), 64'(0));
    dump_q.delete();
    dump_ready = 1'b0;
    #1;
    check({tag, "_done"},        64'(done), 64'(1));
    check({tag, "_valid_after"}, 64'(dump_valid), 64'(0));
    check({tag, "_halted"},      64'(halted), 64'(1));
    check({tag, "_core_en"},     64'(core_en), 64'(0));
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    dump_ready = 1'b0;
    pc_load    = 1'b1;
    pc_val     = '0;
    for (int g = 0; g < N; g++) begin
      inst_mem[g*W +: W] = 32'h1000_0000 + 32'(g);
      data_mem[g*W +: W] = 32'hD000_0000 + 32'(g) * 32'h0101;
    end
    repeat (2) @(negedge clk);
    pc_load = 1'b0;
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1: zero run at words 10,11
    set_inst(10, 32'h0);
    set_inst(11, 32'h0);
    halt_q.push_back('{10, 10, HALT_ZERO, 10});
    run_to_halt("t1");
    // 4: dump with ready toggling
    run_dump("t4", 1'b1);

    // 2: budget only; PC continues from 10 and wraps
    set_inst(10, 32'h1000_000A);
    set_inst(11, 32'h1000_000B);
    halt_q.push_back('{(10 + 60) % N, 60, HALT_BUDGET, 60});
    run_to_halt("t2");
    run_dump("t2d", 1'b0);

    // 3: zero run and budget together
    load_pc(0);
    set_inst(60, 32'h0);
    set_inst(61, 32'h0);
    halt_q.push_back('{60, 60, HALT_BOTH, 60});
    run_to_halt("t3");
    run_dump("t3d", 1'b0);
    set_inst(60, 32'h1000_003C);
    set_inst(61, 32'h1000_003D);

    // 5a: zero run across the wrap
    load_pc(N - 1);
    set_inst(N - 1, 32'h0);
    set_inst(0, 32'h0);
    halt_q.push_back('{N - 1, 0, HALT_ZERO, 0});
    run_to_halt("t5a");
    run_dump("t5ad", 1'b0);

    // 5b: second word of the wrapped window nonzero, only the budget stops it
    load_pc(N - 1);
    set_inst(0, 32'h5);
    halt_q.push_back('{(N - 1 + 60) % N, 60, HALT_BUDGET, 60});
    run_to_halt("t5b");
    run_dump("t5bd", 1'b0);
    set_inst(N - 1, 32'h1000_003F);

    // 6: asynchronous reset in the middle of a dump
    load_pc(0);
    halt_q.push_back('{60, 60, HALT_BUDGET, 60});
    run_to_halt("t6");
    for (int i = 0; i < 20; i++) begin
      dump_ready = 1'b1;
      #1;
      if (dump_addr == 6'd3) break;
      @(negedge clk);
    end
    check("t6_reach_addr3", 64'(dump_addr), 64'(3));
    rst = 1'b0;
    #1;
    check_reset("t6_rst");
    dump_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    load_pc(0);
    halt_q.push_back('{60, 60, HALT_BUDGET, 60});
    run_to_halt("t6r");
    run_dump("t6rd", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
